// File: rtl/pio_wr_arbiter.sv
// Round-robin arbiter for two requesters sharing one PIO slave write port.
// Optional predicted out_port shadow register enabled by macro PIO_ARB_SHADOW_EN.
module pio_wr_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NOP_ACK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [1:0]        op_a,
    input  logic [1:0]        op_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [2:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    output logic              busy,
    output logic [DATA_W-1:0] shadow_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_owner_b;
    logic               r_last_b;
    logic               r_ack_a;
    logic               r_ack_b;
    logic [2:0]         r_addr;
    logic               r_cs;
    logic               r_wr_n;
    logic [31:0]        r_wdata;

    logic               w_elig_a;
    logic               w_elig_b;
    logic               w_any;
    logic               w_grant_b;
    logic [1:0]         w_op;
    logic [DATA_W-1:0]  w_data;
    logic [2:0]         w_addr;

    // With NOP_ACK=0 a reserved-op request is never eligible, so it waits forever
    // without stalling the other requester.
    assign w_elig_a  = req_a && ((NOP_ACK != 0) || (op_a != 2'b11));
    assign w_elig_b  = req_b && ((NOP_ACK != 0) || (op_b != 2'b11));
    assign w_any     = w_elig_a || w_elig_b;
    assign w_grant_b = w_elig_b && (!w_elig_a || !r_last_b);
    assign w_op      = w_grant_b ? op_b : op_a;
    assign w_data    = w_grant_b ? data_b : data_a;

    always_comb begin
        w_addr = 3'd0;
        case (w_op)
            2'b01:   w_addr = 3'd4;
            2'b10:   w_addr = 3'd5;
            default: w_addr = 3'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner_b <= 1'b0;
            r_last_b  <= 1'b1;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_addr    <= '0;
            r_cs      <= 1'b0;
            r_wr_n    <= 1'b1;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack_a <= 1'b0;
                    r_ack_b <= 1'b0;
                    if (w_any) begin
                        r_state   <= S_WRITE;
                        r_owner_b <= w_grant_b;
                        if (w_op != 2'b11) begin
                            r_cs    <= 1'b1;
                            r_wr_n  <= 1'b0;
                            r_addr  <= w_addr;
                            r_wdata <= 32'(w_data);
                        end
                    end
                end
                S_WRITE: begin
                    r_state  <= S_ACK;
                    r_cs     <= 1'b0;
                    r_wr_n   <= 1'b1;
                    r_addr   <= '0;
                    r_wdata  <= '0;
                    r_ack_a  <= !r_owner_b;
                    r_ack_b  <= r_owner_b;
                    r_last_b <= r_owner_b;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack_a <= 1'b0;
                    r_ack_b <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack_a <= 1'b0;
                    r_ack_b <= 1'b0;
                    r_cs    <= 1'b0;
                    r_wr_n  <= 1'b1;
                    r_addr  <= '0;
                    r_wdata <= '0;
                end
            endcase
        end
    end

    assign ack_a          = r_ack_a;
    assign ack_b          = r_ack_b;
    assign pio_address    = r_addr;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wr_n;
    assign pio_writedata  = r_wdata;
    assign busy           = (r_state != S_IDLE);

`ifdef PIO_ARB_SHADOW_EN
    logic [1:0]        r_sh_op;
    logic [DATA_W-1:0] r_sh_data;
    logic [DATA_W-1:0] r_shadow;

    // Operand captured at grant, applied on the WRITE-exit edge like the PIO itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_op   <= '0;
            r_sh_data <= '0;
            r_shadow  <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_sh_op   <= w_op;
                r_sh_data <= w_data;
            end
            if (r_state == S_WRITE) begin
                case (r_sh_op)
                    2'b00:   r_shadow <= r_sh_data;
                    2'b01:   r_shadow <= r_shadow | r_sh_data;
                    2'b10:   r_shadow <= r_shadow & ~r_sh_data;
                    default: r_shadow <= r_shadow;
                endcase
            end
        end
    end

    assign shadow_q = r_shadow;
`else
    assign shadow_q = '0;
`endif

endmodule

// File: tb/tb_pio_wr_arbiter.sv
// Directed bench for pio_wr_arbiter: scoreboard queues of expected writes and acks
// drained by a negedge monitor; shadow expectations follow PIO_ARB_SHADOW_EN.
module tb_pio_wr_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [1:0]    op_a = '0, op_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          ack_a, ack_b;
    logic [2:0]    pio_address;
    logic          pio_chipselect, pio_write_n;
    logic [31:0]   pio_writedata;
    logic          busy;
    logic [DW-1:0] shadow_q;

    pio_wr_arbiter #(.DATA_W(DW), .NOP_ACK(1)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .op_a(op_a), .op_b(op_b),
        .data_a(data_a), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .busy(busy), .shadow_q(shadow_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
    } wr_t;

    wr_t           wr_q[$];
    logic          ack_q[$];
    wr_t           m_wr;
    logic          m_who;
    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] sh_exp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] sh_apply(input logic [DW-1:0] s, input logic [1:0] op,
                                              input logic [DW-1:0] d);
`ifdef PIO_ARB_SHADOW_EN
        case (op)
            2'b00:   return d;
            2'b01:   return s | d;
            2'b10:   return s & ~d;
            default: return s;
        endcase
`else
        return s & d & '0;
`endif
    endfunction

    function automatic logic [2:0] op_addr(input logic [1:0] op);
        return (op == 2'b01) ? 3'd4 : (op == 2'b10) ? 3'd5 : 3'd0;
    endfunction

    // Expected transaction for one grant: bus write (unless reserved op) and ack.
    task automatic expect_txn(input logic who, input logic [1:0] op, input logic [DW-1:0] d,
                              input bit with_ack);
        wr_t e;
        if (op != 2'b11) begin
            e.addr  = op_addr(op);
            e.wdata = 32'(d);
            wr_q.push_back(e);
        end
        if (with_ack) ack_q.push_back(who);
        sh_exp = sh_apply(sh_exp, op, d);
    endtask

    task automatic run_until_acks(input int want, input bit drop_a, input bit drop_b,
                                  input string tag);
        int got = 0;
        for (int c = 0; c < 60 && got < want; c++) begin
            @(negedge clk);
            if (ack_a) begin got++; if (drop_a) req_a = 1'b0; end
            if (ack_b) begin got++; if (drop_b) req_b = 1'b0; end
        end
        check(tag, 32'(got), 32'(want));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ack_a || ack_b) begin
                check("ack_exclusive", 32'(ack_a & ack_b), 32'd0);
                check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
                if (ack_q.size() != 0) begin
                    m_who = ack_q.pop_front();
                    check("ack_who", 32'(ack_b), 32'(m_who));
                end
            end
            if (pio_chipselect) begin
                check("write_expected", 32'(wr_q.size() != 0), 32'd1);
                check("wr_n_low", 32'(pio_write_n), 32'd0);
                if (wr_q.size() != 0) begin
                    m_wr = wr_q.pop_front();
                    check("wr_addr", 32'(pio_address), 32'(m_wr.addr));
                    check("wr_data", pio_writedata, m_wr.wdata);
                end
            end else begin
                check("idle_bus", {28'd0, pio_write_n, pio_address}, 32'h8);
                check("idle_wdata", pio_writedata, 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs", 32'(pio_chipselect), 32'd0);
        check("rst_wr_n", 32'(pio_write_n), 32'd1);
        check("rst_addr", 32'(pio_address), 32'd0);
        check("rst_wdata", pio_writedata, 32'd0);
        check("rst_acks", {30'd0, ack_a, ack_b}, 32'd0);
        check("rst_shadow", 32'(shadow_q), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single write from A, latency check
        expect_txn(1'b0, 2'b00, 8'h5A, 1'b1);
        req_a = 1'b1; op_a = 2'b00; data_a = 8'h5A;
        @(negedge clk);
        check("lat_write_cs", 32'(pio_chipselect), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_ack_a", 32'(ack_a), 32'd1);
        check("single_shadow", 32'(shadow_q), 32'(sh_exp));
        req_a = 1'b0;
        @(negedge clk);
        check("single_idle", 32'(busy), 32'd0);

        // Tie from reset: A wins first
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sh_exp = '0;
        expect_txn(1'b0, 2'b01, 8'h0F, 1'b1);
        expect_txn(1'b1, 2'b10, 8'h03, 1'b1);
        req_a = 1'b1; op_a = 2'b01; data_a = 8'h0F;
        req_b = 1'b1; op_b = 2'b10; data_b = 8'h03;
        run_until_acks(2, 1'b1, 1'b1, "tie_acks");
        repeat (2) @(negedge clk);
        check("tie_shadow", 32'(shadow_q), 32'(sh_exp));

        // Continuous requests: alternation over six grants
        for (int k = 0; k < 3; k++) begin
            expect_txn(1'b0, 2'b00, 8'h11, 1'b1);
            expect_txn(1'b1, 2'b01, 8'h22, 1'b1);
        end
        req_a = 1'b1; op_a = 2'b00; data_a = 8'h11;
        req_b = 1'b1; op_b = 2'b01; data_b = 8'h22;
        run_until_acks(6, 1'b0, 1'b0, "rr_acks");
        req_a = 1'b0; req_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_idle", 32'(busy), 32'd0);
        check("rr_shadow", 32'(shadow_q), 32'(sh_exp));

        // Reserved op from B: ack without bus write
        expect_txn(1'b1, 2'b11, 8'hFF, 1'b1);
        req_b = 1'b1; op_b = 2'b11; data_b = 8'hFF;
        run_until_acks(1, 1'b0, 1'b1, "nop_ack");
        repeat (2) @(negedge clk);
        check("nop_shadow", 32'(shadow_q), 32'(sh_exp));

        // Reset during WRITE: immediate reset values, no ack, A wins next tie
        expect_txn(1'b0, 2'b00, 8'h77, 1'b0);
        req_a = 1'b1; op_a = 2'b00; data_a = 8'h77;
        @(negedge clk);
        check("pre_reset_cs", 32'(pio_chipselect), 32'd1);
        #2 reset = 1'b1; req_a = 1'b0;
        #1;
        check("midrst_cs", 32'(pio_chipselect), 32'd0);
        check("midrst_wr_n", 32'(pio_write_n), 32'd1);
        check("midrst_addr", 32'(pio_address), 32'd0);
        check("midrst_wdata", pio_writedata, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_acks", {30'd0, ack_a, ack_b}, 32'd0);
        check("midrst_shadow", 32'(shadow_q), 32'd0);
        sh_exp = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        expect_txn(1'b0, 2'b01, 8'h80, 1'b1);
        expect_txn(1'b1, 2'b10, 8'h01, 1'b1);
        req_a = 1'b1; op_a = 2'b01; data_a = 8'h80;
        req_b = 1'b1; op_b = 2'b10; data_b = 8'h01;
        run_until_acks(2, 1'b1, 1'b1, "post_rst_acks");
        repeat (2) @(negedge clk);
        check("post_rst_shadow", 32'(shadow_q), 32'(sh_exp));

        // Withdrawn after grant still completes
        expect_txn(1'b0, 2'b00, 8'h3C, 1'b1);
        req_a = 1'b1; op_a = 2'b00; data_a = 8'h3C;
        @(negedge clk);
        req_a = 1'b0;
        run_until_acks(1, 1'b0, 1'b0, "withdrawn_ack");
        repeat (4) @(negedge clk);
        check("withdrawn_shadow", 32'(shadow_q), 32'(sh_exp));

        // Withdrawn before grant: no bus activity
        req_b = 1'b1; op_b = 2'b00; data_b = 8'hC3;
        #2 req_b = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_grant_idle", 32'(busy), 32'd0);
        check("pre_grant_shadow", 32'(shadow_q), 32'(sh_exp));

        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("ack_q_empty", 32'(ack_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
